dmem_access_ctrl: RTL



---
 rtl/dmem_ctrl_pkg.sv | 15 +
 rtl/dmem_access_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
// The state encoding is fixed at 2 bits so it can be probed directly.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } state_e;

    localparam logic [1:0]  ALIGN_MASK = 2'b11;
    localparam logic [31:0] ABORT_DATA = 32'h0;

endpackage

// File: rtl/dmem_access_ctrl.sv
// Sequences datapath loads/stores onto a req/gnt/rvalid memory port,
// stalling the datapath until the access completes, aborts or is rejected.
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic        Stall,
    output logic [31:0] ReadData,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        err_misalign,
    output logic        err_timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_misalign_q, err_misalign_d;
    logic             err_timeout_q, err_timeout_d;
    logic             access;
    logic             stall;

    assign access = MemRead | MemWrite;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        err_misalign_d = err_misalign_q;
        err_timeout_d  = err_timeout_q;
        stall          = 1'b0;

        unique case (state_q)
            IDLE: begin
                stall = access;
                if (access) begin
                    if ((Addr[1:0] & ALIGN_MASK) != 2'b00) begin
                        err_misalign_d = 1'b1;
                        rdata_d        = ABORT_DATA;
                        state_d        = DONE;
                    end else begin
                        addr_d  = {Addr[31:2], 2'b00};
                        wdata_d = WriteData;
                        we_d    = MemWrite;
                        cnt_d   = '0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
                if (mem_gnt) begin
                    state_d = we_q ? DONE : WAIT;
                end else if (cnt_q == CNT_LAST) begin
                    err_timeout_d = 1'b1;
                    rdata_d       = ABORT_DATA;
                    state_d       = DONE;
                end
            end
            WAIT: begin
                stall = 1'b1;
                // Saturating keeps a grant taken on the last REQ cycle from wrapping the count.
                cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_timeout_d = 1'b1;
                    rdata_d       = ABORT_DATA;
                    state_d       = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            err_misalign_q <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            rdata_q        <= rdata_d;
            err_misalign_q <= err_misalign_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    assign Stall        = stall;
    assign ReadData     = rdata_q;
    assign mem_req      = (state_q == REQ);
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign err_misalign = err_misalign_q;
    assign err_timeout  = err_timeout_q;

endmodule
